// File: rtl/frame_unpacker.sv
// Read-side frame unpacker: hunts for {SYNC, len} headers, forwards payload words,
// verifies the trailing 16-bit additive checksum and keeps saturating error/drop counts.
module frame_unpacker #(
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        data_in_valid,
    output logic [15:0] payload_data,
    output logic        payload_valid,
    output logic [7:0]  frame_len,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        busy,
    output logic [7:0]  err_count,
    output logic [7:0]  drop_count
);

    localparam int             GW       = $clog2(TIMEOUT);
    localparam logic [GW-1:0]  GAP_LAST = GW'(TIMEOUT - 1);
    localparam logic [GW-1:0]  GAP_ONE  = GW'(1);
    localparam logic [7:0]     MAX_B    = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [15:0]   sum, sum_nx;
    logic [7:0]    idx, idx_nx;
    logic [GW-1:0] gap, gap_nx;

    logic [15:0]   payload_data_nx;
    logic          payload_valid_nx;
    logic [7:0]    frame_len_nx;
    logic          frame_done_nx;
    logic          frame_ok_nx;
    logic          err_inc, drop_inc;

    logic          hdr_sync, len_legal;
    logic [7:0]    idx_inc;

    assign hdr_sync  = (data_in[15:8] == SYNC);
    assign len_legal = (data_in[7:0] != 8'd0) && (data_in[7:0] <= MAX_B);
    assign idx_inc   = idx + 8'd1;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx         = state;
        sum_nx           = sum;
        idx_nx           = idx;
        gap_nx           = gap;
        payload_data_nx  = payload_data;
        payload_valid_nx = 1'b0;
        frame_len_nx     = frame_len;
        frame_done_nx    = 1'b0;
        frame_ok_nx      = frame_ok;
        err_inc          = 1'b0;
        drop_inc         = 1'b0;

        case (state)
            IDLE: begin
                gap_nx = '0;
                if (data_in_valid) begin
                    if (hdr_sync && len_legal) begin
                        frame_len_nx = data_in[7:0];
                        sum_nx       = 16'd0;
                        idx_nx       = 8'd0;
                        state_nx     = PAYLOAD;
                    end else if (hdr_sync) begin
                        err_inc = 1'b1;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end

            PAYLOAD, CHECK: begin
                if (data_in_valid) begin
                    // a word landing on the would-be timeout cycle still counts
                    gap_nx = '0;
                    if (state == PAYLOAD) begin
                        payload_data_nx  = data_in;
                        payload_valid_nx = 1'b1;
                        sum_nx           = sum + data_in;
                        idx_nx           = idx_inc;
                        if (idx_inc == frame_len)
                            state_nx = CHECK;
                    end else begin
                        frame_done_nx = 1'b1;
                        frame_ok_nx   = (data_in == sum);
                        err_inc       = (data_in != sum);
                        state_nx      = IDLE;
                    end
                end else if (gap == GAP_LAST) begin
                    frame_done_nx = 1'b1;
                    frame_ok_nx   = 1'b0;
                    err_inc       = 1'b1;
                    gap_nx        = '0;
                    state_nx      = IDLE;
                end else begin
                    gap_nx = gap + GAP_ONE;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            sum           <= 16'd0;
            idx           <= 8'd0;
            gap           <= '0;
            payload_data  <= 16'd0;
            payload_valid <= 1'b0;
            frame_len     <= 8'd0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            err_count     <= 8'd0;
            drop_count    <= 8'd0;
        end else begin
            state         <= state_nx;
            sum           <= sum_nx;
            idx           <= idx_nx;
            gap           <= gap_nx;
            payload_data  <= payload_data_nx;
            payload_valid <= payload_valid_nx;
            frame_len     <= frame_len_nx;
            frame_done    <= frame_done_nx;
            frame_ok      <= frame_ok_nx;
            // both counters stick at all-ones
            if (err_inc && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
            if (drop_inc && (drop_count != 8'hFF))
                drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_frame_unpacker.sv
// Randomized scoreboard bench for frame_unpacker: a frame-level model predicts
// payload/done events with their cycle stamps; a monitor pops and compares them.
module tb_frame_unpacker;

    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data_in = 16'd0;
    logic        data_in_valid = 1'b0;
    logic [15:0] payload_data;
    logic        payload_valid;
    logic [7:0]  frame_len;
    logic        frame_done;
    logic        frame_ok;
    logic        busy;
    logic [7:0]  err_count;
    logic [7:0]  drop_count;

    frame_unpacker #(.SYNC(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .payload_data  (payload_data),
        .payload_valid (payload_valid),
        .frame_len     (frame_len),
        .frame_done    (frame_done),
        .frame_ok      (frame_ok),
        .busy          (busy),
        .err_count     (err_count),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          done;
        logic [15:0] data;
        bit          ok;
        logic [7:0]  len;
        int          stamp;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state, frame level
    bit          m_in_frame = 0;
    int          m_want = 0;
    logic [15:0] m_pl[$];
    int          m_gap = 0;
    int          m_err = 0;
    int          m_drop = 0;
    logic [7:0]  m_len = 0;
    bit          m_last_ok = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] sat(input int v);
        return (v > 255) ? 8'hFF : 8'(v);
    endfunction

    task automatic model(input bit v, input logic [15:0] d);
        ev_t e;
        logic [15:0] s;
        if (!m_in_frame) begin
            if (v) begin
                if (d[15:8] == 8'hA5) begin
                    if (d[7:0] >= 1 && int'(d[7:0]) <= MAX_LEN) begin
                        m_in_frame = 1;
                        m_want     = int'(d[7:0]);
                        m_len      = d[7:0];
                        m_gap      = 0;
                        m_pl.delete();
                    end else m_err++;
                end else m_drop++;
            end
        end else if (v) begin
            m_gap = 0;
            if (m_pl.size() < m_want) begin
                m_pl.push_back(d);
                e = '{done: 0, data: d, ok: 0, len: 0, stamp: cyc + 1};
                q.push_back(e);
            end else begin
                s = 16'd0;
                foreach (m_pl[i]) s = s + m_pl[i];
                m_last_ok  = (d == s);
                if (!m_last_ok) m_err++;
                m_in_frame = 0;
                e = '{done: 1, data: 0, ok: m_last_ok, len: m_len, stamp: cyc + 1};
                q.push_back(e);
            end
        end else begin
            m_gap++;
            if (m_gap == TIMEOUT) begin
                m_last_ok  = 0;
                m_err++;
                m_in_frame = 0;
                e = '{done: 1, data: 0, ok: 0, len: m_len, stamp: cyc + 1};
                q.push_back(e);
            end
        end
    endtask

    task automatic step(input bit v, input logic [15:0] d);
        @(negedge clk);
        chk("busy", busy, m_in_frame);
        chk("err_count", err_count, sat(m_err));
        chk("drop_count", drop_count, sat(m_drop));
        chk("frame_len", frame_len, m_len);
        chk("frame_ok", frame_ok, m_last_ok);
        data_in_valid = v;
        data_in       = v ? d : 16'd0;
        model(v, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_payload_data"}, payload_data, 0);
        chk({tag, "_payload_valid"}, payload_valid, 0);
        chk({tag, "_frame_len"}, frame_len, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_frame_ok"}, frame_ok, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_drop_count"}, drop_count, 0);
    endtask

    // monitor: every output event must match the head of the scoreboard
    initial forever begin
        @(negedge clk);
        if (rst) begin
            while (q.size() > 0 && q[0].stamp < cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL missing_event: got none expected done=%0d data=%0h at cycle %0d",
                         q[0].done, q[0].data, q[0].stamp);
                void'(q.pop_front());
            end
            if (payload_valid && frame_done) begin
                n_cmp++;
                n_err++;
                $display("FAIL overlap: got payload_valid=1 frame_done=1 expected at most one (cycle %0d)", cyc);
            end else if (payload_valid || frame_done) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event: got pv=%0d fd=%0d expected none (cycle %0d)",
                             payload_valid, frame_done, cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("ev_kind", frame_done, mon_e.done);
                    chk("ev_cycle", cyc, mon_e.stamp);
                    if (mon_e.done) begin
                        chk("done_ok", frame_ok, mon_e.ok);
                        chk("done_len", frame_len, mon_e.len);
                    end else begin
                        chk("payload_data", payload_data, mon_e.data);
                    end
                end
            end
        end
    end

    initial begin
        int n, hi;
        logic [15:0] w, s;

        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // good frame
        step(1, 16'hA503); step(1, 16'h0001); step(1, 16'h0002);
        step(1, 16'h0003); step(1, 16'h0006);
        idle(3);

        // checksum wrap: bad then good
        step(1, 16'hA502); step(1, 16'h00FF); step(1, 16'hFF01); step(1, 16'h0001);
        step(1, 16'hA502); step(1, 16'h00FF); step(1, 16'hFF01); step(1, 16'h0000);
        idle(3);

        // hunt / illegal lengths
        step(1, 16'h1234); step(1, 16'hA500); step(1, 16'hA511);
        idle(3);

        // timeout, then a word exactly on the boundary cycle
        step(1, 16'hA504); step(1, 16'h0001);
        idle(TIMEOUT + 6);
        step(1, 16'hA504); step(1, 16'h0001);
        idle(TIMEOUT - 1);
        step(1, 16'h0002); step(1, 16'h0003); step(1, 16'h0004); step(1, 16'h000A);
        idle(3);

        // asynchronous reset mid-frame
        step(1, 16'hA504); step(1, 16'h0001);
        @(negedge clk);
        data_in_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check_all_zero("midreset");
        #1 rst = 1'b1;
        m_in_frame = 0; m_err = 0; m_drop = 0; m_len = 0; m_last_ok = 0; m_gap = 0;
        q.delete();
        step(1, 16'hA501); step(1, 16'hBEEF); step(1, 16'hBEEF);
        idle(3);

        // back-to-back bad frames drive err_count into saturation
        for (int i = 0; i < 260; i++) begin
            step(1, 16'hA501); step(1, 16'h0001); step(1, 16'h0000);
        end
        idle(3);

        // randomized mix
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                hi = $urandom_range(0, 255);
                if (hi == 8'hA5) hi = 0;
                step(1, {8'(hi), 8'($urandom_range(0, 255))});
            end else begin
                n = $urandom_range(0, MAX_LEN + 2);
                step(1, {8'hA5, 8'(n)});
                if (n >= 1 && n <= MAX_LEN) begin
                    s = 16'd0;
                    for (int k = 0; k <= n; k++) begin
                        if ($urandom_range(0, 11) == 0) idle($urandom_range(TIMEOUT - 3, TIMEOUT + 3));
                        else if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                        if (k < n) begin
                            w = 16'($urandom());
                            s = s + w;
                            step(1, w);
                        end else begin
                            step(1, ($urandom_range(0, 2) == 0) ? s ^ 16'h0100 : s);
                        end
                    end
                end
            end
        end
        idle(TIMEOUT + 4);

        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frame_unpacker.md
Name: frame_unpacker

Overview:
- Consumer-side block for the 16-bit word stream that the dual-clock buffer delivers on its read side (data word plus valid).
- Runs entirely in the read clock domain. Hunts for a frame header, strips it, and forwards payload words.
- Verifies a 16-bit additive checksum at the end of each frame and reports per-frame status and error statistics to control logic.

Parameters:
- SYNC, 8'hA5, required value of header bits [15:8].
- MAX_LEN, 16, largest legal payload length in words (1..255).
- TIMEOUT, 64, consecutive cycles without a valid word, mid-frame, before the frame is aborted (≥2).

Ports:
- clk  input  1  single clock for the block; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  16  stream word, qualified by data_in_valid.
- data_in_valid  input  1  one word consumed on each cycle this is high; no backpressure.
- payload_data  output  16  registered payload word.
- payload_valid  output  1  one-cycle pulse per forwarded payload word.
- frame_len  output  8  length field of the current or last accepted header.
- frame_done  output  1  one-cycle pulse at the end of a frame (completed or aborted).
- frame_ok  output  1  status of the last frame; updated with frame_done and held otherwise.
- busy  output  1  high while state ≠ IDLE.
- err_count  output  8  saturating count of errors: bad checksum, timeout, illegal length.
- drop_count  output  8  saturating count of non-header words discarded in IDLE.

Behaviour:
- Reset:
  - rst low clears all of the following immediately, regardless of clk: state=IDLE, every output 0, internal sum/index/timeout counters 0.
  - Any frame in progress is discarded with no frame_done.
- Frame format: header {SYNC, N}, then N payload words, then one checksum word.
  - Checksum = sum of the payload words mod 2^16. The header is excluded.
- State IDLE, on a valid word:
  - If [15:8]==SYNC and 1≤N≤MAX_LEN: latch frame_len=N, clear sum and index, go to PAYLOAD.
  - If [15:8]==SYNC and the length is illegal (N=0 or N>MAX_LEN): err_count+1, stay in IDLE, no frame_done.
  - Otherwise: drop_count+1, stay in IDLE.
- State PAYLOAD, on a valid word:
  - payload_data=word and payload_valid=1 on the next cycle (latency 1).
  - sum+=word, wrapping mod 2^16; index+1.
  - After the Nth word, go to CHECK.
- State CHECK, on a valid word:
  - Next cycle: frame_done=1, frame_ok=(word==sum), go to IDLE.
  - On mismatch: err_count+1.
- Timeout (PAYLOAD/CHECK only):
  - The gap counter resets on every valid word and increments on every cycle without one.
  - On the TIMEOUT-th consecutive empty cycle: frame_done=1, frame_ok=0, err_count+1, go to IDLE.
  - A valid word arriving on that same cycle wins: it is processed normally and the counter resets.
- Back-to-back frames:
  - A header may arrive the cycle immediately after the checksum word; the block is already in IDLE and accepts it.
  - Full throughput is one word per cycle with no dead cycles.
- Output timing: payload_valid and frame_done are never high in the same cycle. busy drops in the same cycle frame_done rises.
- Counters: err_count and drop_count saturate at 255 and never wrap. They are cleared only by reset.
- frame_ok and frame_len hold their values between frames.

Test Plan:
- Good frame: A503,0001,0002,0003,0006 on consecutive cycles -> payload_valid pulses with 0001/0002/0003; then frame_done=1, frame_ok=1, frame_len=3, err_count=0.
- Checksum wrap/error: A502,00FF,FF01,0001 -> sum wraps to 0000; frame_done=1, frame_ok=0, err_count=1. A follow-up frame A502,00FF,FF01,0000 -> frame_ok=1.
- Hunt/illegal: 1234,A500,A511 with MAX_LEN=16 -> drop_count=1, err_count=2, no payload_valid, no frame_done, busy=0 throughout.
- Timeout: A504,0001, then valid low -> frame_done=1, frame_ok=0 exactly 64 cycles after 0001 is sampled; err_count=1, busy=0. A valid word on cycle 64 instead -> no abort.
- Reset mid-frame: A504,0001, then rst low for 1 cycle between edges -> outputs 0 immediately. Then A501,BEEF,BEEF -> frame_ok=1, frame_len=1.
- Saturation/back-to-back: 260 frames with bad checksums sent with no gaps -> 260 frame_done pulses, err_count=255 and held there.
